// File: rtl/neuron_unit.sv
// neuron_unit: chunk-serial dot product onto a bias, requantized to one signed byte.
// Optional saturation event counter is built only when NEURON_SAT_CNT_EN is defined.
module neuron_unit #(
  parameter int unsigned WRITE_WIDTH    = 8,
  parameter int unsigned READ_WIDTH_MUL = 27,
  parameter int unsigned NUM_CHUNKS     = 35,
  parameter int unsigned ACC_WIDTH      = 32,
  localparam int unsigned CW = $clog2(NUM_CHUNKS),
  localparam int unsigned DW = READ_WIDTH_MUL * WRITE_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CW-1:0]          cfg_first_chunk,
  input  logic [CW:0]            cfg_num_chunks,
  input  logic [ACC_WIDTH-1:0]   cfg_bias,
  input  logic [4:0]             cfg_shift,
  input  logic                   cfg_relu,
  input  logic                   cfg_last,
  output logic                   rp_load,
  output logic [CW-1:0]          rp_load_val,
  output logic                   rp_inc,
  input  logic [DW-1:0]          mem_rdata,
  output logic                   w_rd,
  input  logic [DW-1:0]          w_data,
  output logic                   busy,
  output logic                   done,
  output logic [WRITE_WIDTH-1:0] out_data,
  output logic                   out_we,
  output logic                   out_next_chunk,
  output logic [15:0]            sat_count
);

  localparam int unsigned PW = 2 * WRITE_WIDTH + $clog2(READ_WIDTH_MUL);
  localparam int unsigned RW = ACC_WIDTH + 1;
  localparam logic signed [RW-1:0] R_MAX = RW'((1 << (WRITE_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] R_MIN = RW'(-(1 << (WRITE_WIDTH - 1)));

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_t;

  state_t                  r_state, w_state_nxt;
  logic [CW:0]             r_rem;
  logic                    r_v_data, r_v_psum;
  logic signed [PW-1:0]    r_psum, w_psum;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic [4:0]              r_shift;
  logic                    r_relu, r_last;
  logic                    r_busy, r_done, r_out_we, r_next;
  logic [WRITE_WIDTH-1:0]  r_out_data;
  logic                    w_accept, w_load, w_inc;
  logic signed [RW-1:0]    w_rnd, w_sum, w_r;
  logic [WRITE_WIDTH-1:0]  w_q;
  logic                    w_sat;

  // Next state and fetch strobes; reset masks every strobe in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_inc       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (cfg_num_chunks != '0) begin
            w_load      = 1'b1;
            w_state_nxt = S_ISSUE;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_ISSUE: begin
        if (r_rem != '0) w_inc = 1'b1;
        else             w_state_nxt = S_DRAIN;
      end
      S_DRAIN: if (!r_v_data) w_state_nxt = S_OUT;
      S_OUT:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (rst) begin
      w_accept = 1'b0;
      w_load   = 1'b0;
      w_inc    = 1'b0;
    end
  end

  // Lane-wise signed products summed at full width
  always_comb begin
    w_psum = '0;
    for (int i = 0; i < READ_WIDTH_MUL; i++) begin
      w_psum = w_psum + PW'($signed(mem_rdata[i*WRITE_WIDTH +: WRITE_WIDTH]) *
                            $signed(w_data[i*WRITE_WIDTH +: WRITE_WIDTH]));
    end
  end

  // Round-half-up shift, clip to a signed byte, then optional ReLU
  always_comb begin
    w_rnd = '0;
    if (r_shift != 5'd0) w_rnd = RW'(1) << (r_shift - 5'd1);
    w_sum = RW'(r_acc) + w_rnd;
    w_r   = w_sum >>> r_shift;
    w_q   = w_r[WRITE_WIDTH-1:0];
    w_sat = 1'b0;
    if (w_r > R_MAX) begin
      w_q   = R_MAX[WRITE_WIDTH-1:0];
      w_sat = 1'b1;
    end else if (w_r < R_MIN) begin
      w_q   = R_MIN[WRITE_WIDTH-1:0];
      w_sat = !r_relu;
    end
    if (r_relu && w_r[RW-1]) w_q = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rem      <= '0;
      r_v_data   <= 1'b0;
      r_v_psum   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_out_we   <= 1'b0;
      r_next     <= 1'b0;
      r_out_data <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
      r_v_data <= w_load | w_inc;
      r_v_psum <= r_v_data;
      if (r_v_data) r_psum <= w_psum;
      if (w_accept) begin
        r_rem   <= cfg_num_chunks - (CW+1)'(1);
        r_acc   <= cfg_bias;
        r_shift <= cfg_shift;
        r_relu  <= cfg_relu;
        r_last  <= cfg_last;
      end else begin
        if (w_inc)    r_rem <= r_rem - (CW+1)'(1);
        if (r_v_psum) r_acc <= r_acc + ACC_WIDTH'(r_psum);
      end
      r_out_we <= (r_state == S_OUT);
      r_done   <= (r_state == S_OUT);
      r_next   <= (r_state == S_OUT) && r_last;
      if (r_state == S_OUT) r_out_data <= w_q;
    end
  end

`ifdef NEURON_SAT_CNT_EN
  logic [15:0] r_sat_cnt;

  // Sticky at all-ones; only reset clears it
  always_ff @(posedge clk) begin
    if (rst) r_sat_cnt <= '0;
    else if ((r_state == S_OUT) && w_sat && (r_sat_cnt != 16'hFFFF))
      r_sat_cnt <= r_sat_cnt + 16'd1;
  end
  assign sat_count = r_sat_cnt;
`else
  logic w_unused_sat;
  assign w_unused_sat = w_sat;
  assign sat_count    = '0;
`endif

  assign rp_load        = w_load;
  assign rp_load_val    = cfg_first_chunk;
  assign rp_inc         = w_inc;
  assign w_rd           = w_load | w_inc;
  assign busy           = r_busy;
  assign done           = r_done;
  assign out_we         = r_out_we;
  assign out_next_chunk = r_next;
  assign out_data       = r_out_data;

endmodule

// File: tb/tb_neuron_unit.sv
// Directed bench for neuron_unit with a behavioural chunk memory and weight source.
module tb_neuron_unit;
  localparam int unsigned W  = 8;
  localparam int unsigned L  = 27;
  localparam int unsigned NC = 35;
  localparam int unsigned AW = 32;
  localparam int unsigned CW = $clog2(NC);
  localparam int unsigned DW = L * W;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [CW-1:0] cfg_first_chunk;
  logic [CW:0]   cfg_num_chunks;
  logic [AW-1:0] cfg_bias;
  logic [4:0]    cfg_shift;
  logic          cfg_relu, cfg_last;
  logic          rp_load, rp_inc, w_rd, busy, done, out_we, out_next_chunk;
  logic [CW-1:0] rp_load_val;
  logic [DW-1:0] mem_rdata, w_data;
  logic [W-1:0]  out_data;
  logic [15:0]   sat_count;

  neuron_unit #(.WRITE_WIDTH(W), .READ_WIDTH_MUL(L), .NUM_CHUNKS(NC), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_first_chunk(cfg_first_chunk), .cfg_num_chunks(cfg_num_chunks),
    .cfg_bias(cfg_bias), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .cfg_last(cfg_last),
    .rp_load(rp_load), .rp_load_val(rp_load_val), .rp_inc(rp_inc),
    .mem_rdata(mem_rdata), .w_rd(w_rd), .w_data(w_data),
    .busy(busy), .done(done), .out_data(out_data), .out_we(out_we),
    .out_next_chunk(out_next_chunk), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  int mem [NC][L];
  int wt  [8][L];
  int ptr = 0, widx = 0;
  logic s_load = 1'b0, s_inc = 1'b0, s_wrd = 1'b0;
  logic [CW-1:0] s_val = '0;
  int cnt_load = 0, cnt_inc = 0, cnt_wrd = 0, cnt_we = 0, cnt_both = 0, last_load_val = -1;
  int checks = 0, errors = 0, exp_sat_cnt = 0;

  function automatic logic [DW-1:0] chunk_bits(input int c);
    logic [DW-1:0] b;
    for (int l = 0; l < L; l++) b[l*W +: W] = W'(mem[c][l]);
    return b;
  endfunction

  function automatic logic [DW-1:0] wt_bits(input int k);
    logic [DW-1:0] b;
    for (int l = 0; l < L; l++) b[l*W +: W] = W'(wt[k][l]);
    return b;
  endfunction

  // Strobes are sampled mid-cycle and acted on at the next edge
  always @(negedge clk) begin
    s_load <= rp_load;
    s_inc  <= rp_inc;
    s_wrd  <= w_rd;
    s_val  <= rp_load_val;
    if (rp_load) begin
      cnt_load      <= cnt_load + 1;
      last_load_val <= int'(rp_load_val);
    end
    if (rp_inc)            cnt_inc  <= cnt_inc + 1;
    if (w_rd)              cnt_wrd  <= cnt_wrd + 1;
    if (out_we)            cnt_we   <= cnt_we + 1;
    if (rp_load && rp_inc) cnt_both <= cnt_both + 1;
  end

  always @(posedge clk) begin
    if (s_load) begin
      ptr       <= int'(s_val);
      mem_rdata <= chunk_bits(int'(s_val));
    end else if (s_inc) begin
      ptr       <= (ptr + 1) % int'(NC);
      mem_rdata <= chunk_bits((ptr + 1) % int'(NC));
    end
    if (s_wrd) begin
      w_data <= wt_bits(s_load ? 0 : widx);
      widx   <= s_load ? 1 : widx + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_neuron(input string tag, input int first, input int n, input int bias,
                            input int shift, input bit relu, input bit last,
                            input logic [7:0] exp_data, input bit exp_sat);
    int l0, i0, w0, e0, b0, lat;
    @(posedge clk); #1;
    l0 = cnt_load; i0 = cnt_inc; w0 = cnt_wrd; e0 = cnt_we; b0 = cnt_both;
    cfg_first_chunk = CW'(first);
    cfg_num_chunks  = (CW+1)'(n);
    cfg_bias        = AW'(bias);
    cfg_shift       = 5'(shift);
    cfg_relu        = relu;
    cfg_last        = last;
    start           = 1'b1;
    @(negedge clk);
    chk({tag, " idle_at_start"}, 64'(busy), 0);
    chk({tag, " we_low_at_start"}, 64'(out_we), 0);
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    for (int k = 1; k <= n + 8 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) chk({tag, " busy_cycle1"}, 64'(busy), 1);
      if (out_we) lat = k;
    end
    chk({tag, " latency"}, 64'(lat), 64'(n + 3));
    chk({tag, " out_data"}, 64'(out_data), 64'(exp_data));
    chk({tag, " done"}, 64'(done), 1);
    chk({tag, " next_chunk"}, 64'(out_next_chunk), 64'(last));
    chk({tag, " busy_low_at_done"}, 64'(busy), 0);
`ifdef NEURON_SAT_CNT_EN
    if (exp_sat) exp_sat_cnt++;
`endif
    chk({tag, " sat_count"}, 64'(sat_count), 64'(exp_sat_cnt));
    @(posedge clk); #1;
    chk({tag, " we_one_cycle"}, 64'(out_we), 0);
    chk({tag, " rp_load_cnt"}, 64'(cnt_load - l0), 64'(n > 0 ? 1 : 0));
    chk({tag, " rp_inc_cnt"}, 64'(cnt_inc - i0), 64'(n > 0 ? n - 1 : 0));
    chk({tag, " w_rd_cnt"}, 64'(cnt_wrd - w0), 64'(n));
    chk({tag, " load_and_inc"}, 64'(cnt_both - b0), 0);
    chk({tag, " we_cnt"}, 64'(cnt_we - e0), 1);
  endtask

  initial begin
    int e0, lat;
    for (int c = 0; c < int'(NC); c++)
      for (int l = 0; l < int'(L); l++) mem[c][l] = 0;
    for (int k = 0; k < 8; k++)
      for (int l = 0; l < int'(L); l++) wt[k][l] = k + 1;
    for (int l = 0; l < int'(L); l++) begin
      mem[5][l]  = 1;
      mem[10][l] = l - 13;
      mem[33][l] = 2;
      mem[34][l] = -1;
      mem[0][l]  = 3;
    end

    // Reset with a start pending: nothing may fetch or write
    rst = 1'b1; start = 1'b1;
    cfg_first_chunk = '0; cfg_num_chunks = (CW+1)'(2); cfg_bias = '0;
    cfg_shift = '0; cfg_relu = 1'b0; cfg_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst busy", 64'(busy), 0);
    chk("rst done", 64'(done), 0);
    chk("rst out_we", 64'(out_we), 0);
    chk("rst next_chunk", 64'(out_next_chunk), 0);
    chk("rst out_data", 64'(out_data), 0);
    chk("rst rp_load", 64'(rp_load), 0);
    chk("rst rp_inc", 64'(rp_inc), 0);
    chk("rst w_rd", 64'(w_rd), 0);
    chk("rst sat_count", 64'(sat_count), 0);
    @(posedge clk); #1 rst = 1'b0; start = 1'b0;

    // 27 lanes of 1*1
    run_neuron("n1_ones", 5, 1, 0, 0, 1'b0, 1'b0, 8'd27, 1'b0);
    // chunks 33,34,0: 27*(2*1 - 1*2 + 3*3) - 100 = 143, (143+1)>>1 = 72
    run_neuron("n3_wrap", 33, 3, -100, 1, 1'b0, 1'b0, 8'd72, 1'b0);
    chk("n3_wrap load_val", 64'(last_load_val), 33);
    // per-lane data: sum (l-13)^2 = 1638, (1638+8)>>4 = 102; relu passes positives
    for (int l = 0; l < int'(L); l++) wt[0][l] = l - 13;
    run_neuron("lanes", 10, 1, 0, 4, 1'b1, 1'b0, 8'd102, 1'b0);
    for (int l = 0; l < int'(L); l++) wt[0][l] = 1;
    // N=0 paths exercise bias-only requant
    run_neuron("pos_sat", 0, 0, 1000, 2, 1'b0, 1'b0, 8'd127, 1'b1);
    run_neuron("round_neg", 0, 0, -6, 2, 1'b0, 1'b0, 8'hFF, 1'b0);
    run_neuron("relu_neg", 0, 0, -6, 2, 1'b1, 1'b0, 8'h00, 1'b0);
    run_neuron("neg_sat", 0, 0, -1000, 0, 1'b0, 1'b0, 8'h80, 1'b1);

    // Back-to-back: start held high, config changed while busy
    @(posedge clk); #1;
    e0 = cnt_we;
    cfg_first_chunk = CW'(5); cfg_num_chunks = (CW+1)'(1); cfg_bias = '0;
    cfg_shift = '0; cfg_relu = 1'b0; cfg_last = 1'b0; start = 1'b1;
    @(negedge clk);
    chk("b2b a_accept", 64'(busy), 0);
    @(posedge clk); #1;
    cfg_num_chunks = '0; cfg_bias = AW'(-6); cfg_shift = 5'd2; cfg_last = 1'b1;
    lat = 0;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(negedge clk);
      if (out_we) lat = k;
    end
    chk("b2b a_latency", 64'(lat), 4);
    chk("b2b a_data", 64'(out_data), 27);
    chk("b2b a_next", 64'(out_next_chunk), 0);
    chk("b2b b_accept", 64'(busy), 0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("b2b gap_we", 64'(out_we), 0);
    chk("b2b gap_next", 64'(out_next_chunk), 0);
    chk("b2b b_busy", 64'(busy), 1);
    lat = 0;
    for (int k = 2; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (out_we) lat = k;
    end
    chk("b2b b_latency", 64'(lat), 3);
    chk("b2b b_data", 64'(out_data), 64'(8'hFF));
    chk("b2b b_next", 64'(out_next_chunk), 1);
    @(posedge clk); #1;
    chk("b2b we_cnt", 64'(cnt_we - e0), 2);
    cfg_last = 1'b0;

    // Abort an N=4 neuron with reset in its cycle 2
    @(posedge clk); #1;
    e0 = cnt_we;
    cfg_first_chunk = '0; cfg_num_chunks = (CW+1)'(4); cfg_bias = '0;
    cfg_shift = '0; cfg_relu = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("abort rp_inc_in_rst", 64'(rp_inc), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort busy", 64'(busy), 0);
    chk("abort out_we", 64'(out_we), 0);
    repeat (8) @(negedge clk);
    @(posedge clk); #1;
    chk("abort no_write", 64'(cnt_we - e0), 0);
    exp_sat_cnt = 0;
    run_neuron("after_abort", 33, 3, -100, 1, 1'b0, 1'b0, 8'd72, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
